alu_share_ctrl: RTL

Controller that shares one combinational 8-bit ALU between two requesters. It uses round-robin arbitration and valid/ready handshakes on both the request and response sides. It registers each accepted operation, holds the ALU inputs stable for the operation's execution time, captures the ALU output, and returns it to the requester that issued it. It sits between the two requesting engines and the ALU instance, and drives the ALU's A, B and Op inputs directly.

---
 rtl/alu_share_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational 8-bit ALU between two requesters.
// Requests are arbitrated round-robin. The accepted operation is registered and
// held on the ALU inputs for its execution time. The ALU result is captured and
// returned to the requester that issued the operation.
//
// Handshake rule (request and response sides): a transfer happens on a rising
// clock edge where valid and ready are both high. The source keeps valid and its
// data stable until that edge. Ready may depend combinationally on valid.
module alu_share_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int OP_W    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [7:0]      req0_a,
  input  logic [7:0]      req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [7:0]      req1_a,
  input  logic [7:0]      req1_b,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [15:0]     rsp_result,
  output logic            rsp_cb,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [15:0]     alu_out,
  input  logic            alu_cb,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(2);
  localparam logic [3:0]      MUL_CNT = 4'(MUL_LAT - 1);

  state_t          state;
  logic            rr_ptr;
  logic            grant_id;
  logic [3:0]      exec_cnt;
  logic            win0;
  logic            win1;
  logic [OP_W-1:0] win_op;

  // Arbitration: the lone valid requester wins; on contention rr_ptr decides.
  // Only offered in IDLE. Reset forces ready low while it is asserted.
  always_comb begin
    win0   = 1'b0;
    win1   = 1'b0;
    if (rst_n && (state == IDLE)) begin
      win0 = req0_valid && (!req1_valid || !rr_ptr);
      win1 = req1_valid && (!req0_valid ||  rr_ptr);
    end
    win_op = win1 ? req1_op : req0_op;
  end

  assign req0_ready = win0;
  assign req1_ready = win1;
  assign dbg_state  = state;

  // Control FSM. Holds the operation on the ALU, captures and masks the result,
  // and hands the result back. rr_ptr moves only when a response completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      grant_id   <= 1'b0;
      exec_cnt   <= 4'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_op     <= '0;
      rsp_result <= 16'h0000;
      rsp_cb     <= 1'b0;
      rsp_valid  <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win0 || win1) begin
            grant_id <= win1;
            alu_op   <= win_op;
            alu_a    <= win1 ? req1_a : req0_a;
            alu_b    <= win1 ? req1_b : req0_b;
            exec_cnt <= (win_op == OP_MUL) ? MUL_CNT : 4'd0;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (exec_cnt == 4'd0) begin
            // Only multiply produces a 16-bit result. The upper byte is
            // meaningless for the other ops. cb is stale unless add/sub.
            rsp_result <= (alu_op == OP_MUL) ? alu_out : {8'h00, alu_out[7:0]};
            rsp_cb     <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) && alu_cb;
            rsp_valid  <= grant_id ? 2'b10 : 2'b01;
            state      <= RESP;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= 2'b00;
            rr_ptr    <= ~grant_id;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
